fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fq_mem.sv | 39 +++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared fetch-side constants, the queue entry record and the
//                instruction-memory address check used when a word is pushed.
//  Contents    : IM_BASE / IM_LIMIT   legal instruction-memory word range
//                PC_RESET             fetch PC after reset
//                NOP                  instruction presented when nothing valid
//                FQ_DEPTH_DEFAULT     default fetch queue depth
//                fq_entry_t           {pc, instr, adel} queue entry
//                pc_addr_error()      fetch address error predicate
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

   localparam logic [31:0] IM_BASE          = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT         = 32'h0000_6FFC;
   localparam logic [31:0] PC_RESET         = 32'h0000_3000;
   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam int          FQ_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fq_entry_t;

   // A fetch is in error when it is not word aligned or falls outside the
   // instruction memory window. IM_LIMIT is the address of the last word.
   function automatic logic pc_addr_error(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fq_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fq_mem
//  Description : Fetch queue entry storage. One synchronous write port and one
//                asynchronous read port. Contents are not reset; the control
//                logic never presents an unwritten entry as valid.
//  Ports       : clk    in   write clock
//                we     in   write enable
//                waddr  in   write index
//                wdata  in   entry to write
//                raddr  in   read index
//                rdata  out  entry at raddr (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module fq_mem #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 65,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Circular instruction fetch queue between fetch and decode.
//                Entries carry {pc, instr, adel}. No bypass: a word pushed
//                into an empty queue is visible one cycle later. Flush clears
//                the queue and drops any same-cycle push; reset wins over all.
//  Ports       : clk        in   rising-edge clock
//                reset      in   synchronous active-high reset
//                flush      in   discard all entries (redirect)
//                in_valid   in   fetch presents a word
//                in_pc      in   byte address of fetched word
//                in_instr   in   fetched instruction
//                in_ready   out  queue has room (fetch PC enable)
//                out_valid  out  head entry valid for decode
//                out_ready  in   decode consumes head this cycle
//                out_pc     out  head PC (0 when empty)
//                out_instr  out  head instruction (NOP when empty)
//                out_adel   out  head fetch address error (0 when empty)
//                count      out  occupied entries, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = FQ_DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_instr,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_instr,
   output logic          out_adel,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam int            EW         = $bits(fq_entry_t);

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          push;
   logic          pop;
   fq_entry_t     wr_entry;
   fq_entry_t     rd_entry;
   logic [EW-1:0] rd_bits;

   // Handshake status comes from registered count only, so in_ready never
   // depends combinationally on in_valid or flush.
   assign in_ready  = (count < FULL_COUNT);
   assign out_valid = (count != '0);

   assign push = in_valid  && in_ready  && !flush;
   assign pop  = out_valid && out_ready && !flush;

   assign wr_entry.pc    = in_pc;
   assign wr_entry.instr = in_instr;
   assign wr_entry.adel  = pc_addr_error(in_pc);

   // DEPTH is a power of two, so pointer increment wraps modulo DEPTH
   // naturally in AW bits.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fq_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (tail),
      .wdata (wr_entry),
      .raddr (head),
      .rdata (rd_bits)
   );

   assign rd_entry = fq_entry_t'(rd_bits);

   // Storage is not reset, so empty-state outputs are forced here.
   assign out_pc    = out_valid ? rd_entry.pc    : 32'h0;
   assign out_instr = out_valid ? rd_entry.instr : NOP;
   assign out_adel  = out_valid ? rd_entry.adel  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue (DEPTH=4): directed
//                vector table, hand-written corner sequences and randomized
//                traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } ref_entry_t;

   typedef struct {
      logic        rst;
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ordy;
      int          exp_count;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic        exp_adel;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_adel;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   ref_entry_t  model[$];
   logic [31:0] delivered[$];

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_adel  (out_adel),
      .count     (count)
   );

   function automatic logic ref_adel(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("m_count",    32'(count),     32'(model.size()));
      check("m_in_ready", 32'(in_ready),  32'(model.size() < DEPTH));
      check("m_valid",    32'(out_valid), 32'(model.size() != 0));
      if (model.size() != 0) begin
         check("m_pc",    out_pc,         model[0].pc);
         check("m_instr", out_instr,      model[0].instr);
         check("m_adel",  32'(out_adel),  32'(model[0].adel));
      end else begin
         check("m_pc0",    out_pc,        32'h0);
         check("m_instr0", out_instr,     32'h0);
         check("m_adel0",  32'(out_adel), 32'h0);
      end
   endtask

   // One clock cycle: drive inputs, predict, clock, then compare. Called
   // 1 time unit after a rising edge so outputs are settled.
   task automatic cyc(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy);
      logic       m_push;
      logic       m_pop;
      ref_entry_t e;
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = instr;
      out_ready = ordy;
      m_push = !rst && !fl && iv && (model.size() < DEPTH);
      m_pop  = !rst && !fl && ordy && (model.size() != 0);
      #1;
      if (m_pop) delivered.push_back(out_pc);
      e.pc = pc; e.instr = instr; e.adel = ref_adel(pc);
      @(posedge clk);
      #1;
      if (rst || fl) begin
         model.delete();
      end else begin
         if (m_pop)  void'(model.pop_front());
         if (m_push) model.push_back(e);
      end
      check_model();
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                               input logic [31:0] pc, input logic [31:0] instr,
                               input logic ordy, input int ec, input logic ev,
                               input logic [31:0] epc, input logic [31:0] ein,
                               input logic ead);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
      v.exp_count = ec; v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ein; v.exp_adel = ead;
      return v;
   endfunction

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      @(posedge clk); #1;

      // ---------------- directed vector table ----------------
      //              rst  fl   iv   pc            instr         ordy cnt v    exp_pc        exp_instr     adel
      vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,0, 1'b0,32'h0,       32'h0,       1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_3000,32'h3C01_0001,1'b0,1,1'b1,32'h0000_3000,32'h3C01_0001,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_3004,32'h1111_0004,1'b0,2,1'b1,32'h0000_3000,32'h3C01_0001,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_3008,32'h1111_0008,1'b0,3,1'b1,32'h0000_3000,32'h3C01_0001,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_300C,32'h1111_000C,1'b0,4,1'b1,32'h0000_3000,32'h3C01_0001,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_3010,32'h1111_0010,1'b0,4,1'b1,32'h0000_3000,32'h3C01_0001,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,3, 1'b1,32'h0000_3004,32'h1111_0004,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,2, 1'b1,32'h0000_3008,32'h1111_0008,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,1, 1'b1,32'h0000_300C,32'h1111_000C,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,0, 1'b0,32'h0,       32'h0,       1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,0, 1'b0,32'h0,       32'h0,       1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_3002,32'h2222_0002,1'b0,1,1'b1,32'h0000_3002,32'h2222_0002,1'b1));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_7000,32'h2222_7000,1'b1,1,1'b1,32'h0000_7000,32'h2222_7000,1'b1));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0000_3004,32'h2222_3004,1'b1,1,1'b1,32'h0000_3004,32'h2222_3004,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,0, 1'b0,32'h0,       32'h0,       1'b0));

      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy);
         check($sformatf("v%0d_count", i), 32'(count),     32'(vecs[i].exp_count));
         check($sformatf("v%0d_rdy", i),   32'(in_ready),  32'(vecs[i].exp_count < DEPTH));
         check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_pc", i),    out_pc,         vecs[i].exp_pc);
         check($sformatf("v%0d_instr", i), out_instr,      vecs[i].exp_instr);
         check($sformatf("v%0d_adel", i),  32'(out_adel),  32'(vecs[i].exp_adel));
      end

      // ---------------- steady push+pop from count=2 ----------------
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_3100, 32'hAAAA_0000, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_3104, 32'hAAAA_0001, 1'b0);
      delivered.delete();
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'h0000_3108 + 32'(4 * i), 32'hAAAA_0002 + 32'(i), 1'b1);
         check("steady_count", 32'(count), 32'd2);
      end
      check("steady_npop", 32'(delivered.size()), 32'd10);
      foreach (delivered[i]) check("steady_order", delivered[i], 32'h0000_3100 + 32'(4 * i));

      // ---------------- flush with same-cycle push ----------------
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0000_3020 + 32'(4 * i), 32'hBBBB_0000 + 32'(i), 1'b0);
      check("pre_flush_count", 32'(count), 32'd3);
      delivered.delete();
      cyc(1'b0, 1'b1, 1'b1, 32'h0000_3040, 32'hBBBB_0040, 1'b1);
      check("flush_count", 32'(count),     32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_instr", out_instr,      32'h0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_3044, 32'hBBBB_0044, 1'b1);
      idle(1'b1);
      check("flush_npop", 32'(delivered.size()), 32'd1);
      foreach (delivered[i]) check("flush_nodrop", 32'(delivered[i] == 32'h0000_3040), 32'd0);

      // ---------------- reset + flush while full ----------------
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0000_3200 + 32'(4 * i), 32'hCCCC_0000 + 32'(i), 1'b0);
      check("full_count", 32'(count), 32'd4);
      delivered.delete();
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_3300, 32'hCCCC_0300, 1'b1);
      check("rstfl_count", 32'(count),     32'd0);
      check("rstfl_rdy",   32'(in_ready),  32'd1);
      check("rstfl_valid", 32'(out_valid), 32'd0);
      check("rstfl_nopop", 32'(delivered.size()), 32'd0);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 600; i++) begin
         logic        r_rst, r_fl, r_iv, r_ordy;
         logic [31:0] r_pc;
         r_rst  = ($urandom_range(0, 63) == 0);
         r_fl   = ($urandom_range(0, 15) == 0);
         r_iv   = ($urandom_range(0, 3) != 0);
         r_ordy = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 5))
            0:       r_pc = 32'h0000_3000 + (32'($urandom_range(0, 4095)) << 2) + 32'($urandom_range(1, 3));
            1:       r_pc = $urandom();
            2: begin
               case ($urandom_range(0, 3))
                  0:       r_pc = 32'h0000_2FFC;
                  1:       r_pc = 32'h0000_3000;
                  2:       r_pc = 32'h0000_6FFC;
                  default: r_pc = 32'h0000_7000;
               endcase
            end
            default: r_pc = 32'h0000_3000 + (32'($urandom_range(0, 4095)) << 2);
         endcase
         cyc(r_rst, r_fl, r_iv, r_pc, $urandom(), r_ordy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
